multi_dir_traffic_ctrl: RTL and testbench
=========================================

Name: multi_dir_traffic_ctrl

Overview:
Parametrised traffic-light sequencer for NUM_DIR approach directions. Each direction gets a GREEN → YELLOW → ALL_RED cycle, then service rotates round-robin. The duration of each phase is set by a parameter and counted by an internal dwell timer. Sits below the intersection top level and drives the per-direction lamp outputs directly.

Parameters:
NUM_DIR, 4, number of directions served; legal range ≥2.
GREEN_CYCLES, 8, clock cycles per GREEN phase; must be ≥1.
YELLOW_CYCLES, 3, clock cycles per YELLOW phase; must be ≥1.
ALLRED_CYCLES, 2, clock cycles per ALL_RED clearance phase; must be ≥1.
CNT_W, $clog2(max of the three durations)+1, dwell counter width; derived, do not override.
DIR_W, $clog2(NUM_DIR), width of the direction index.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  when 0, the dwell counter freezes and all outputs hold.
red  output  NUM_DIR  per-direction red lamp.
yellow  output  NUM_DIR  per-direction yellow lamp.
green  output  NUM_DIR  per-direction green lamp.
state  output  2  current phase: 00 ALL_RED, 01 GREEN, 10 YELLOW.
active_dir  output  DIR_W  direction currently (or next) being served.
phase_done  output  1  one-cycle pulse on the last cycle of every phase.

Behaviour:
- All outputs are registered.
- Reset values: state=ALL_RED, active_dir=0, counter=ALLRED_CYCLES-1, red=all ones, yellow=0, green=0, phase_done=0.
- Phase timing:
  - On entry to a phase, the counter loads DUR-1.
  - The counter decrements on each cycle with enable=1.
  - When the counter is 0 and enable=1, the next phase is entered on the following edge.
  - Each phase therefore lasts exactly DUR enabled cycles.
- Transitions:
  - ALL_RED → GREEN; active_dir is unchanged.
  - GREEN → YELLOW.
  - YELLOW → ALL_RED; active_dir increments at this transition and wraps from NUM_DIR-1 to 0.
- Lamp decode, registered and updated on the same edge as state:
  - GREEN: green[active_dir]=1, every other direction red=1.
  - YELLOW: yellow[active_dir]=1, every other direction red=1.
  - ALL_RED: red=all ones.
- Invariant: exactly one lamp is lit per direction, and at most one direction is non-red at any time. The bench asserts this.
- phase_done = (counter==0) && enable. It is not asserted while enable=0.
- enable deasserted mid-phase: counter, state and lamps hold. On re-enable, counting resumes with the remaining count; the phase is not restarted.
- Reset mid-phase: immediate asynchronous return to the reset values; the partial phase is discarded.
- Unused state encoding 11: next edge goes to ALL_RED with the counter reloaded, active_dir preserved.

Optional Feature:
Macro TLC_FLASH_MODE_EN.
- Defined:
  - Adds input `flash` (1 bit).
  - While flash=1, the FSM and counter hold, and every direction's yellow toggles each cycle; red and green are 0.
  - The toggle register resets to 0 and restarts at 0 on each flash assertion.
  - On flash deassert, the controller enters ALL_RED with a full ALLRED_CYCLES count and the same active_dir.
  - flash has priority over enable.
- Undefined: no `flash` port; the behaviour is as above with no flash logic.

Decomposition:
- Package tlc_pkg:
  - phase enum (ALL_RED=2'b00, GREEN=2'b01, YELLOW=2'b10).
  - The state width constant.
  - A function returning the duration for a given phase.
- Sub-module tlc_dwell_timer (inputs load, load_val, en; outputs cnt, expired). It is instantiated once.

Test Plan:
- NUM_DIR=3, G=4, Y=2, AR=1; release reset at edge 0, enable=1:
  - state sequence is AR(1) G(4) Y(2) per direction.
  - active_dir is 0,1,2,0, changing every 7 cycles.
  - Full rotation is 21 cycles; phase_done pulses every phase end.
- Lamp invariant check over 200 random-enable cycles: one-hot per direction, and at most one non-red direction.
- Drop enable for 5 cycles at G counter=2: state holds and phase_done=0; after re-enable, GREEN lasts 3 more cycles.
- Assert reset asynchronously in YELLOW of dir 2: outputs go to reset values before the next edge; after release, the sequence restarts at AR/dir 0.
- NUM_DIR=2, AR=1: wrap from dir 1 to dir 0 is verified with green[0] asserted 1 cycle after YELLOW ends plus AR.
- With TLC_FLASH_MODE_EN, assert flash in GREEN dir 1 for 6 cycles:
  - yellow toggles 0,1,0,1,0,1 on all directions.
  - After flash deassert, ALL_RED lasts 1 cycle, then green[1].

Source files
------------

// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the multi-direction traffic-light sequencer.
//   STATE_W   : width of the phase/state encoding
//   phase_t   : phase encoding (ALL_RED=00, GREEN=01, YELLOW=10; 11 unused)
//   phase_dur : dwell length in clock cycles of a given phase
// -----------------------------------------------------------------------------
package tlc_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ALL_RED = 2'b00,
      GREEN   = 2'b01,
      YELLOW  = 2'b10
   } phase_t;

   // Anything that is not GREEN or YELLOW dwells as ALL_RED, which also covers
   // the unused encoding when it is forced back to ALL_RED.
   function automatic int phase_dur(input logic [STATE_W-1:0] ph,
                                    input int green_c,
                                    input int yellow_c,
                                    input int allred_c);
      case (ph)
         GREEN:   return green_c;
         YELLOW:  return yellow_c;
         default: return allred_c;
      endcase
   endfunction

endpackage

// File: rtl/multi_dir_traffic_ctrl_if.sv
// -----------------------------------------------------------------------------
// multi_dir_traffic_ctrl_if
// Lamp/handshake bundle of the traffic-light sequencer.
//   enable     : count enable (slave drives)
//   flash      : flashing-yellow request, only with TLC_FLASH_MODE_EN defined
//   red/yellow/green : per-direction lamps (master drives)
//   state      : current phase, active_dir : direction being served
//   phase_done : pulse on the last cycle of every phase
// Modports: master = controller side, slave = surrounding logic side.
// -----------------------------------------------------------------------------
interface multi_dir_traffic_ctrl_if #(
   parameter int NUM_DIR = 4
);
   import tlc_pkg::*;

   localparam int DIR_W = $clog2(NUM_DIR);

   logic                 enable;
`ifdef TLC_FLASH_MODE_EN
   logic                 flash;
`endif
   logic [NUM_DIR-1:0]   red;
   logic [NUM_DIR-1:0]   yellow;
   logic [NUM_DIR-1:0]   green;
   logic [STATE_W-1:0]   state;
   logic [DIR_W-1:0]     active_dir;
   logic                 phase_done;

   modport master (
      input  enable,
`ifdef TLC_FLASH_MODE_EN
      input  flash,
`endif
      output red, yellow, green, state, active_dir, phase_done
   );

   modport slave (
      output enable,
`ifdef TLC_FLASH_MODE_EN
      output flash,
`endif
      input  red, yellow, green, state, active_dir, phase_done
   );

endinterface

// File: rtl/tlc_dwell_timer.sv
// -----------------------------------------------------------------------------
// tlc_dwell_timer
// Down-counting phase dwell timer.
//   clk, reset : clock, asynchronous active-high reset (counter -> RESET_VAL)
//   load       : load load_val (takes priority over counting)
//   load_val   : value loaded on phase entry (duration - 1)
//   en         : decrement by one while non-zero
//   cnt        : current count
//   expired    : count is zero (last cycle of the phase when counting)
// -----------------------------------------------------------------------------
module tlc_dwell_timer #(
   parameter int               CNT_W     = 4,
   parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= RESET_VAL;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (en && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign cnt     = cnt_reg;
   assign expired = (cnt_reg == '0);

endmodule

// File: rtl/multi_dir_traffic_ctrl.sv
// -----------------------------------------------------------------------------
// multi_dir_traffic_ctrl
// Round-robin traffic-light sequencer: each direction gets GREEN -> YELLOW ->
// ALL_RED, then service moves to the next direction.
//   clk   : system clock (rising edge)
//   reset : asynchronous active-high reset
//   bus   : multi_dir_traffic_ctrl_if.master (enable in; lamps, state,
//           active_dir, phase_done out)
// Optional feature macro: TLC_FLASH_MODE_EN adds bus.flash (all-yellow flashing
// with the sequencer frozen; leaves through a full ALL_RED phase).
// -----------------------------------------------------------------------------
module multi_dir_traffic_ctrl
   import tlc_pkg::*;
#(
   parameter  int NUM_DIR       = 4,
   parameter  int GREEN_CYCLES  = 8,
   parameter  int YELLOW_CYCLES = 3,
   parameter  int ALLRED_CYCLES = 2,
   localparam int MAX_GY        = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES,
   localparam int MAX_DUR       = (MAX_GY > ALLRED_CYCLES) ? MAX_GY : ALLRED_CYCLES,
   localparam int CNT_W         = $clog2(MAX_DUR) + 1,
   localparam int DIR_W         = $clog2(NUM_DIR)
) (
   input  logic                    clk,
   input  logic                    reset,
   multi_dir_traffic_ctrl_if.master bus
);

   logic [STATE_W-1:0] state_reg, state_next;
   logic [DIR_W-1:0]   dir_reg, dir_next;
   logic [NUM_DIR-1:0] red_reg, yellow_reg, green_reg;
   logic [NUM_DIR-1:0] red_next, yellow_next, green_next;
   logic [NUM_DIR-1:0] dir_hit;
   logic [CNT_W-1:0]   cnt, load_val;
   logic               expired, load, run;
   logic               flash_in, flash_mode, flash_tog, tog_next, flash_exit;

`ifdef TLC_FLASH_MODE_EN
   // flash_mode mirrors whether the lamps currently show the flash pattern.
   assign flash_in = bus.flash;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flash_mode <= 1'b0;
         flash_tog  <= 1'b0;
      end else begin
         flash_mode <= flash_in;
         flash_tog  <= flash_in ? tog_next : 1'b0;
      end
   end
`else
   assign flash_in   = 1'b0;
   assign flash_mode = 1'b0;
   assign flash_tog  = 1'b0;
`endif

   // First flashing cycle shows yellow off, then it alternates.
   assign tog_next   = flash_mode ? ~flash_tog : 1'b0;
   assign flash_exit = flash_mode & ~flash_in;
   // Flash overrides enable: the timer only runs outside flash.
   assign run        = bus.enable & ~flash_in;

   tlc_dwell_timer #(
      .CNT_W     (CNT_W),
      .RESET_VAL (CNT_W'(ALLRED_CYCLES - 1))
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .en       (run),
      .cnt      (cnt),
      .expired  (expired)
   );

   assign load_val = CNT_W'(phase_dur(state_next, GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES) - 1);

   // State register (lamps are registered alongside so they change with state).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ALL_RED;
         dir_reg    <= '0;
         red_reg    <= '1;
         yellow_reg <= '0;
         green_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         dir_reg    <= dir_next;
         red_reg    <= red_next;
         yellow_reg <= yellow_next;
         green_reg  <= green_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      load       = 1'b0;
      if (!flash_in) begin
         if (flash_exit) begin
            state_next = ALL_RED;
            load       = 1'b1;
         end else begin
            case (state_reg)
               ALL_RED: if (run && expired) begin
                  state_next = GREEN;
                  load       = 1'b1;
               end
               GREEN: if (run && expired) begin
                  state_next = YELLOW;
                  load       = 1'b1;
               end
               YELLOW: if (run && expired) begin
                  state_next = ALL_RED;
                  load       = 1'b1;
                  dir_next   = (dir_reg == DIR_W'(NUM_DIR - 1)) ? '0 : dir_reg + 1'b1;
               end
               default: begin
                  // Unused encoding: recover to ALL_RED, keep the direction.
                  state_next = ALL_RED;
                  load       = 1'b1;
               end
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_dir_hit
         assign dir_hit[gi] = (dir_next == DIR_W'(gi));
      end
   endgenerate

   // Output decode of the upcoming state into the lamp registers.
   always_comb begin
      red_next    = '1;
      yellow_next = '0;
      green_next  = '0;
      if (flash_in) begin
         red_next    = '0;
         yellow_next = {NUM_DIR{tog_next}};
      end else begin
         case (state_next)
            GREEN: begin
               red_next   = ~dir_hit;
               green_next = dir_hit;
            end
            YELLOW: begin
               red_next    = ~dir_hit;
               yellow_next = dir_hit;
            end
            default: ;
         endcase
      end
   end

   assign bus.red        = red_reg;
   assign bus.yellow     = yellow_reg;
   assign bus.green      = green_reg;
   assign bus.state      = state_reg;
   assign bus.active_dir = dir_reg;
   // Marks the cycle whose edge ends the phase, so it must follow enable live;
   // it stays low while flashing and on the cycle leaving flash.
   assign bus.phase_done = (cnt == '0) & bus.enable & ~flash_in & ~flash_mode;

endmodule

// File: tb/tb_multi_dir_traffic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_dir_traffic_ctrl
// Two sequencers side by side (3 and 2 directions, G=4 Y=2 AR=1) sharing
// clock, reset, enable (and flash when TLC_FLASH_MODE_EN is defined).
// -----------------------------------------------------------------------------
module tb_multi_dir_traffic_ctrl;

   localparam int G_C  = 4;
   localparam int Y_C  = 2;
   localparam int AR_C = 1;
   localparam logic [1:0] P_AR = 2'b00;
   localparam logic [1:0] P_G  = 2'b01;
   localparam logic [1:0] P_Y  = 2'b10;

   typedef struct {
      int         inst;
      logic [1:0] st;
      logic [1:0] dir;
      logic [2:0] r;
      logic [2:0] y;
      logic [2:0] g;
      logic       pd;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   // Reference model state per instance.
   int         nd[2] = '{3, 2};
   logic [1:0] m_st[2];
   int         m_cnt[2];
   int         m_dir[2];
   bit         m_fm[2];
   bit         m_tog[2];

   always #5 clk = ~clk;

   multi_dir_traffic_ctrl_if #(.NUM_DIR(3)) ifa ();
   multi_dir_traffic_ctrl_if #(.NUM_DIR(2)) ifb ();

   multi_dir_traffic_ctrl #(
      .NUM_DIR(3), .GREEN_CYCLES(G_C), .YELLOW_CYCLES(Y_C), .ALLRED_CYCLES(AR_C)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.master)
   );

   multi_dir_traffic_ctrl #(
      .NUM_DIR(2), .GREEN_CYCLES(G_C), .YELLOW_CYCLES(Y_C), .ALLRED_CYCLES(AR_C)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.master)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i]  = P_AR;
         m_cnt[i] = AR_C - 1;
         m_dir[i] = 0;
         m_fm[i]  = 1'b0;
         m_tog[i] = 1'b0;
      end
   endtask

   function automatic exp_t mk(int i, bit en, bit fl);
      exp_t e;
      logic [2:0] all;
      all    = (i == 0) ? 3'b111 : 3'b011;
      e.inst = i;
      e.st   = m_st[i];
      e.dir  = 2'(m_dir[i]);
      e.r    = all;
      e.y    = 3'b000;
      e.g    = 3'b000;
      if (m_fm[i]) begin
         e.r = 3'b000;
         e.y = m_tog[i] ? all : 3'b000;
      end else if (m_st[i] == P_G) begin
         e.r[m_dir[i]] = 1'b0;
         e.g[m_dir[i]] = 1'b1;
      end else if (m_st[i] == P_Y) begin
         e.r[m_dir[i]] = 1'b0;
         e.y[m_dir[i]] = 1'b1;
      end
      e.pd = en && !fl && !m_fm[i] && (m_cnt[i] == 0);
      return e;
   endfunction

   task automatic model_edge(int i, bit en, bit fl);
      if (fl) begin
         m_tog[i] = m_fm[i] ? !m_tog[i] : 1'b0;
         m_fm[i]  = 1'b1;
      end else if (m_fm[i]) begin
         m_fm[i]  = 1'b0;
         m_tog[i] = 1'b0;
         m_st[i]  = P_AR;
         m_cnt[i] = AR_C - 1;
      end else if (en) begin
         if (m_cnt[i] > 0) begin
            m_cnt[i]--;
         end else if (m_st[i] == P_AR) begin
            m_st[i] = P_G;  m_cnt[i] = G_C - 1;
         end else if (m_st[i] == P_G) begin
            m_st[i] = P_Y;  m_cnt[i] = Y_C - 1;
         end else begin
            m_st[i] = P_AR; m_cnt[i] = AR_C - 1;
            m_dir[i] = (m_dir[i] + 1) % nd[i];
         end
      end
   endtask

   function automatic exp_t obs(int i);
      exp_t o;
      o.inst = i;
      if (i == 0) begin
         o.st = ifa.state;  o.dir = ifa.active_dir;
         o.r  = ifa.red;    o.y   = ifa.yellow;   o.g = ifa.green;
         o.pd = ifa.phase_done;
      end else begin
         o.st = ifb.state;  o.dir = {1'b0, ifb.active_dir};
         o.r  = {1'b0, ifb.red}; o.y = {1'b0, ifb.yellow}; o.g = {1'b0, ifb.green};
         o.pd = ifb.phase_done;
      end
      return o;
   endfunction

   // One clock cycle: drive, push expectation, compare at negedge, advance model.
   task automatic cyc(bit en, bit fl);
      exp_t  e, o;
      string nm;
      bit    ok;
      int    nonred;
      ifa.enable = en;
      ifb.enable = en;
`ifdef TLC_FLASH_MODE_EN
      ifa.flash = fl;
      ifb.flash = fl;
`endif
      sb.push_back(mk(0, en, fl));
      sb.push_back(mk(1, en, fl));
      @(negedge clk);
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         o  = obs(e.inst);
         nm = (e.inst == 0) ? "A" : "B";
         chk({nm, ".state"},      8'(o.st),  8'(e.st));
         chk({nm, ".active_dir"}, 8'(o.dir), 8'(e.dir));
         chk({nm, ".red"},        8'(o.r),   8'(e.r));
         chk({nm, ".yellow"},     8'(o.y),   8'(e.y));
         chk({nm, ".green"},      8'(o.g),   8'(e.g));
         chk({nm, ".phase_done"}, 8'(o.pd),  8'(e.pd));
         if (!m_fm[e.inst]) begin
            ok = 1'b1;
            nonred = 0;
            for (int d = 0; d < nd[e.inst]; d++) begin
               if ((int'(o.r[d]) + int'(o.y[d]) + int'(o.g[d])) != 1) ok = 1'b0;
               if (!o.r[d]) nonred++;
            end
            if (nonred > 1) ok = 1'b0;
            chk({nm, ".lamp_invariant"}, 8'(ok), 8'd1);
         end
      end
      if (!reset) begin
         model_edge(0, en, fl);
         model_edge(1, en, fl);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      reset      = 1'b1;
      ifa.enable = 1'b0;
      ifb.enable = 1'b0;
`ifdef TLC_FLASH_MODE_EN
      ifa.flash  = 1'b0;
      ifb.flash  = 1'b0;
`endif
      model_reset();
      @(posedge clk);
      #1;

      // Reset values while reset is held.
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);

      // Release; the next edge is edge 0. One full 21-cycle rotation of A.
      reset = 1'b0;
      for (int i = 0; i < 21; i++) begin
         if ((i % 7) == 0) chk("rotation.dir_A", 8'(ifa.active_dir), 8'((i / 7) % 3));
         cyc(1'b1, 1'b0);
      end
      chk("rotation.back_to_dir0", 8'(ifa.active_dir), 8'd0);

      // Freeze GREEN at counter 2 for 5 cycles, then 3 more GREEN cycles.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("hold.pre_state", 8'(ifa.state), 8'(P_G));
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      chk("hold.still_green", 8'(ifa.state), 8'(P_G));
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      chk("hold.green_ends", 8'(ifa.state), 8'(P_Y));

      // Random enable.
      for (int i = 0; i < 200; i++) cyc($urandom_range(0, 3) != 0, 1'b0);

      // Asynchronous reset while A is in YELLOW of direction 2.
      k = 0;
      while (!(m_st[0] == P_Y && m_dir[0] == 2) && k < 100) begin
         cyc(1'b1, 1'b0);
         k++;
      end
      chk("find_yellow_dir2", 8'(ifa.state == P_Y && ifa.active_dir == 2'd2), 8'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst.state_A",  8'(ifa.state),      8'(P_AR));
      chk("async_rst.dir_A",    8'(ifa.active_dir), 8'd0);
      chk("async_rst.red_A",    8'(ifa.red),        8'h07);
      chk("async_rst.yellow_A", 8'(ifa.yellow),     8'h00);
      chk("async_rst.green_A",  8'(ifa.green),      8'h00);
      chk("async_rst.red_B",    8'(ifb.red),        8'h03);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Restart from AR/dir 0; B wraps 1 -> 0 and shows green[0] at cycle 15.
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0);
      chk("wrap.green_B",   8'(ifb.green),      8'h01);
      chk("wrap.dir_B",     8'(ifb.active_dir), 8'd0);
      chk("restart.green_A", 8'(ifa.green),     8'h04);

`ifdef TLC_FLASH_MODE_EN
      // Flash for 6 cycles while A is in GREEN of direction 1.
      k = 0;
      while (!(m_st[0] == P_G && m_dir[0] == 1) && k < 100) begin
         cyc(1'b1, 1'b0);
         k++;
      end
      chk("find_green_dir1", 8'(ifa.green), 8'h02);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      chk("flash_exit.all_red", 8'(ifa.red), 8'h07);
      cyc(1'b1, 1'b0);
      chk("flash_exit.green1", 8'(ifa.green), 8'h02);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
